// File: rtl/bit_scan_ctrl_if.sv
// Handshake and result bus between a word producer and the bit scan controller.
interface bit_scan_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;
    logic             ser_out;
    logic             hit;

    // Producer side: issues scan requests and reads back results
    modport master (
        output start, data_in,
        input  busy, done, match_count, ser_out, hit
    );

    // Controller side
    modport slave (
        input  start, data_in,
        output busy, done, match_count, ser_out, hit
    );
endinterface

// File: rtl/bit_scan_ctrl.sv
// Word-level scan controller: shifts a loaded word MSB-first through a
// "1-then-0" Moore detector and reports how many matches were seen.
module bit_scan_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    bit_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
    typedef enum logic [1:0] {DET_A, DET_B, DET_C} det_t;

    state_t           state;
    det_t             det;
    det_t             det_nxt;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             busy_r;
    logic             done_r;
    logic             ser_r;
    logic             hit_r;

    // Detector transition; any unused encoding recovers to A
    function automatic det_t det_step(input det_t cur, input logic b);
        case (cur)
            DET_A:   return b ? DET_B : DET_A;
            DET_B:   return b ? DET_B : DET_C;
            DET_C:   return b ? DET_B : DET_A;
            default: return DET_A;
        endcase
    endfunction

    // Next detector state for the bit on the shift register MSB
    assign det_nxt = det_step(det, shreg[WIDTH-1]);

    // Saturating increment so the count never wraps
    assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

    // Controller FSM, detector and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            det    <= DET_A;
            shreg  <= '0;
            idx    <= '0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ser_r  <= 1'b0;
            hit_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg  <= bus.data_in;
                        idx    <= '0;
                        count  <= '0;
                        det    <= DET_A;
                        hit_r  <= 1'b0;
                        ser_r  <= bus.data_in[WIDTH-1];
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    det   <= det_nxt;
                    hit_r <= (det_nxt == DET_C);
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    idx   <= idx + IDX_W'(1);
                    if (hit_r) begin
                        count <= count_inc;
                    end
                    if (idx == IDX_W'(WIDTH - 1)) begin
                        ser_r <= 1'b0;
                        state <= FLUSH;
                    end else begin
                        ser_r <= shreg[WIDTH-2];
                    end
                end
                FLUSH: begin
                    // Count the Moore output left by the final bit, then park the detector
                    if (hit_r) begin
                        count <= count_inc;
                    end
                    det    <= DET_A;
                    hit_r  <= 1'b0;
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    det    <= DET_A;
                    hit_r  <= 1'b0;
                    ser_r  <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.match_count = count;
    assign bus.ser_out     = ser_r;
    assign bus.hit         = hit_r;
endmodule

// File: doc/bit_scan_ctrl.md
# bit_scan_ctrl

Scan controller that sequences the serial "1-then-0" pattern detector over a parallel word. On `start` it loads a WIDTH-bit word, shifts it MSB-first through an embedded Moore detector with three states (overlap permitted), and counts detections. It then pulses `done` with the final count. It sits between a parallel producer (register file or bus slave) and the bit-level detection logic, so software can request a whole-word scan instead of driving `in` bit by bit.

## Interface
- `WIDTH`, default 8: word length in bits. Must be ≥ 2.
- `CNT_W`, default 4: width of `match_count`. Must be ≥ clog2(WIDTH/2 + 1).

- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst`  input  1  reset. Synchronous, active-high.
- `start`  input  1  scan request. Sampled only in IDLE.
- `data_in`  input  WIDTH  word to scan. Captured on the accepting edge.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle pulse marking the result valid.
- `match_count`  output  CNT_W  number of detections in the last scan. Held until the next accepted start.
- `ser_out`  output  1  bit currently presented to the detector.
- `hit`  output  1  Moore output of the embedded detector.

## Operation
- **Controller states:** IDLE, SHIFT, FLUSH, DONE.
- **IDLE:**
  - On `start`=1: load shift register with `data_in`, clear bit index, clear `match_count`, set detector to state A, go to SHIFT.
  - On `start`=0: stay in IDLE.
- **SHIFT:**
  - `ser_out` = shift register MSB. The detector consumes `ser_out` on each edge, and the shift register moves left by one.
  - After the edge that consumes bit 0 (index == WIDTH-1), go to FLUSH.
- **FLUSH:** one cycle. The detector holds and consumes nothing; it exists so the Moore `hit` for the final bit gets counted. Go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **Detector next-state (Moore):**
  - A: in=0 → A; in=1 → B.
  - B: in=0 → C; in=1 → B.
  - C: in=0 → A; in=1 → B.
  - `hit` = (det == C). Unused encoding → A.
  - The detector is re-initialised to A at every accepted start, so no match spans two words.
- **Counting:**
  - `match_count` increments on any edge where `hit`=1 and state ∈ {SHIFT, FLUSH}.
  - The count saturates at all-ones and never wraps.
- **Start handling:** `start` is ignored in SHIFT, FLUSH and DONE. There is no queuing. A `start` in the DONE cycle is dropped; `start` must be reasserted in IDLE.
- **Idle outputs:** `ser_out`=0 and `hit`=0 in IDLE. The detector is held in A.

## Timing
- **Reset:** `rst`=1 at any edge, including mid-scan, forces:
  - state IDLE and detector A
  - `busy`=0, `done`=0, `hit`=0, `ser_out`=0
  - `match_count`=0, shift register 0
  - Any in-progress scan is discarded.
- **Scan schedule:** let start be accepted at edge E0.
  - The detector consumes bit WIDTH-1 at E1 and bit 0 at E_WIDTH.
  - FLUSH occupies the cycle after E_WIDTH.
  - The final count update happens at E_WIDTH+1.
  - `done`=1 in the cycle after E_WIDTH+1, with final `match_count` already stable.
- **Latency:** `busy` rises the cycle after E0 and stays high for WIDTH+2 cycles (WIDTH SHIFT + FLUSH + DONE).
- **Throughput:** the earliest next acceptance is the edge after the DONE cycle, so at most one scan per WIDTH+3 cycles.
- **`hit` lag:** `hit` lags the consumed `0` by one cycle. A match whose `0` is bit 0 is counted during FLUSH.
- **`match_count` stability:** the count may change during SHIFT/FLUSH. It is valid only when `done`=1 and stays stable until the next accepted start.

## Test plan
- **Reset then alternating word:** reset, then `data_in`=8'b10101010 → `done` high 10 cycles after the accepting edge, `match_count`=4, `hit` high in 4 distinct cycles.
- **Mixed patterns:**
  - 8'b11110000 → 1
  - 8'b00000000 → 0
  - 8'b11111111 → 0
  - 8'b01101101 → 2
- **Last-bit match:** 8'b00000010 → count becomes 1 in FLUSH, `done` with `match_count`=1.
- **Start while busy:** `start` held high for the whole scan of 8'b10000000 plus the DONE cycle, with `data_in` changing → only the first word is scanned, count=1. A new scan begins only on the edge after DONE, because `start` is still high in IDLE.
- **Reset mid-operation:** `rst` asserted at SHIFT bit 3 → next cycle `busy`=0, `match_count`=0, `hit`=0, no `done` pulse. A subsequent scan of 8'b10101010 gives 4.
- **Back-to-back words:** 8'b00000001 then 8'b01111111 → counts 0 and 0, confirming the detector is re-initialised and no cross-word match occurs.
